// File: rtl/rf_pkg.sv
// Shared definitions for the general-purpose register file and its scoreboard.
//   - Default DATA_W / ADDR_W / NUM_RD / NUM_WR values
//   - REG_ZERO: the hard-wired zero register address
//   - slice_lo(): base bit of port k inside a flattened multi-port bus
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Port k of a flattened bus whose ports are 'width' bits wide starts at bit k*width.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for the register file.
//   clk, reset          : clock, asynchronous active-high reset
//   iss_en, iss_addr    : mark a destination register busy
//   flush               : clear every busy bit (highest priority)
//   wr_en, wr_addr      : writeback ports; a write clears the busy bit of its target
//   busy                : one busy bit per register (bit 0 is always 0)
//   busy_cnt            : popcount of busy, registered (lags busy by one cycle)
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic [ADDR_W:0]  r_busy_cnt;
  logic [ADDR_W:0]  w_pop;

  // Register 0 is never busy: its next state is tied low.
  assign w_busy_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_busy
      logic w_wr_hit;

      always_comb begin
        w_wr_hit = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] == ADDR_W'(gi))) begin
            w_wr_hit = 1'b1;
          end
        end
      end

      // flush > issue > write: a same-cycle issue means a newer producer is
      // still outstanding, so the older writeback must not clear the bit.
      always_comb begin
        w_busy_next[gi] = r_busy[gi];
        if (flush) begin
          w_busy_next[gi] = 1'b0;
        end else if (iss_en && (iss_addr == ADDR_W'(gi))) begin
          w_busy_next[gi] = 1'b1;
        end else if (w_wr_hit) begin
          w_busy_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pop = w_pop + (ADDR_W+1)'(r_busy[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_pop;
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_busy_cnt;

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-port general-purpose register file with write-to-read bypass and a
// busy-bit scoreboard (decode stage: read ports feed operand fetch, write
// ports come from writeback, the issue port marks pending destinations).
//   clk, reset          : clock, asynchronous active-high reset
//   rd_addr / rd_data   : NUM_RD combinational read ports (register 0 reads 0)
//   rd_ready            : operand valid (addr 0, same-cycle bypass, or not busy)
//   wr_en/addr/data     : NUM_WR write ports, higher index wins on collision
//   wr_pc, wr_instr     : writer identity, only used by the write trace
//   iss_en, iss_addr    : mark a destination busy
//   flush               : clear all busy bits
//   busy_cnt            : registered number of busy registers
// Optional feature: define RF_TRACE_EN to print one line per effective write.
module gpr_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*32-1:0]     wr_pc,
  input  logic [NUM_WR*32-1:0]     wr_instr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] w_wr_addr [NUM_WR];
  logic [DATA_W-1:0] w_wr_data [NUM_WR];
  logic [DEPTH-1:0]  w_busy;

  generate
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
      assign w_wr_addr[gi] = wr_addr[slice_lo(gi, ADDR_W) +: ADDR_W];
      assign w_wr_data[gi] = wr_data[slice_lo(gi, DATA_W) +: DATA_W];
    end
  endgenerate

  // Ports are applied in ascending order so the highest-index writer's
  // assignment is the one that lands when addresses collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (w_wr_addr[j] != ZERO_ADDR)) begin
          r_mem[w_wr_addr[j]] <= w_wr_data[j];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_data;
      logic              w_hit;
      logic              w_zero;

      assign w_addr = rd_addr[slice_lo(gi, ADDR_W) +: ADDR_W];
      assign w_zero = (w_addr == ZERO_ADDR);

      // Array value, overridden by any matching writer; the ascending scan
      // leaves the highest-index match in w_data.
      always_comb begin
        w_data = r_mem[w_addr];
        w_hit  = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (w_wr_addr[j] == w_addr)) begin
            w_hit  = 1'b1;
            w_data = w_wr_data[j];
          end
        end
        if (w_zero) begin
          w_data = '0;
        end
      end

      assign rd_data[slice_lo(gi, DATA_W) +: DATA_W] = w_data;
      assign rd_ready[gi] = w_zero | w_hit | ~w_busy[w_addr];
    end
  endgenerate

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (w_busy),
    .busy_cnt (busy_cnt)
  );

`ifdef RF_TRACE_EN
  // Only the winning port of a collision is reported; writes to $0 are silent.
  always @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < NUM_WR; j++) begin
        logic shadowed;
        shadowed = 1'b0;
        for (int k = j + 1; k < NUM_WR; k++) begin
          if (wr_en[k] && (w_wr_addr[k] == w_wr_addr[j])) begin
            shadowed = 1'b1;
          end
        end
        if (wr_en[j] && (w_wr_addr[j] != ZERO_ADDR) && !shadowed) begin
          $display("%h @%h: $%d <= %h", wr_instr[j*32 +: 32], wr_pc[j*32 +: 32],
                   w_wr_addr[j], w_wr_data[j]);
        end
      end
    end
  end
`else
  // Trace-only inputs are kept on the interface but have no function here.
  logic w_unused_trace;
  assign w_unused_trace = ^{wr_pc, wr_instr};
`endif

endmodule

// File: tb/tb_gpr_file_sb.sv
module tb_gpr_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_ready;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW*32-1:0] wr_pc;
  logic [NW*32-1:0] wr_instr;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic [AW:0]      busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  gpr_file_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR),
    .NUM_WR (NW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_pc    (wr_pc),
    .wr_instr (wr_instr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem  [32];
  logic          m_busy [32];
  int            m_cnt;

  function automatic int count_busy();
    int c = 0;
    for (int r = 0; r < 32; r++) c += m_busy[r] ? 1 : 0;
    return c;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r]  <= '0;
        m_busy[r] <= 1'b0;
      end
      m_cnt <= 0;
    end else begin
      m_cnt <= count_busy();
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] != 0) m_mem[wr_addr[p*AW +: AW]] <= wr_data[p*DW +: DW];
      end
      for (int r = 1; r < 32; r++) begin
        logic written;
        written = 1'b0;
        for (int p = 0; p < NW; p++) begin
          if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == r) written = 1'b1;
        end
        if (flush) m_busy[r] <= 1'b0;
        else if (iss_en && int'(iss_addr) == r) m_busy[r] <= 1'b1;
        else if (written) m_busy[r] <= 1'b0;
      end
    end
  end

  // What a read of 'a' must return right now, given stored state and live writers.
  task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic rdy);
    logic hit;
    hit = 1'b0;
    d   = m_mem[a];
    for (int p = 0; p < NW; p++) begin
      if (wr_en[p] && wr_addr[p*AW +: AW] == a) begin
        hit = 1'b1;
        d   = wr_data[p*DW +: DW];
      end
    end
    if (a == 0) d = '0;
    rdy = (a == 0) || hit || !m_busy[a];
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] ed;
    logic          er;
    for (int k = 0; k < NR; k++) begin
      model_read(rd_addr[k*AW +: AW], ed, er);
      check($sformatf("cyc_rd_data%0d", k), 64'(rd_data[k*DW +: DW]), 64'(ed));
      check($sformatf("cyc_rd_ready%0d", k), 64'(rd_ready[k]), 64'(er));
    end
    check("cyc_busy_cnt", 64'(busy_cnt), 64'(m_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic do_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
    wr_pc[p*32 +: 32]   = 32'h0000_1000 + 32'(a) * 4;
    wr_instr[p*32 +: 32] = 32'h0000_0013 | (32'(a) << 7);
  endtask

  task automatic do_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic do_iss(input logic [AW-1:0] a);
    iss_en   = 1'b1;
    iss_addr = a;
  endtask

  initial begin
    reset    = 1'b1;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_pc    = '0;
    wr_instr = '0;
    iss_addr = '0;
    idle();
    tick();
    tick();
    #1;
    check("reset_busy_cnt", 64'(busy_cnt), 64'd0);
    check("reset_ready", 64'(rd_ready), 64'h3);
    reset = 1'b0;

    // 1: reset mid-stream after $5 = DEADBEEF (with $6 pending)
    tick();
    do_wr(0, 5'd5, 32'hDEADBEEF);
    do_iss(5'd6);
    tick();
    idle();
    do_rd(0, 5'd5);
    do_rd(1, 5'd6);
    tick();
    #1;
    check("t1_stored", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("t1_cnt_before", 64'(busy_cnt), 64'd1);
    check("t1_busy6", 64'(rd_ready[1]), 64'd0);
    reset = 1'b1;
    #1;
    check("t1_async_data", 64'(rd_data[31:0]), 64'd0);
    check("t1_async_cnt", 64'(busy_cnt), 64'd0);
    check("t1_async_ready", 64'(rd_ready), 64'h3);
    tick();
    reset = 1'b0;

    // 2: bypass then array read of $3
    do_wr(0, 5'd3, 32'h1234);
    do_rd(0, 5'd3);
    #2;
    check("t2_bypass", 64'(rd_data[31:0]), 64'h1234);
    tick();
    idle();
    #2;
    check("t2_array", 64'(rd_data[31:0]), 64'h1234);

    // 3: $0 ignores writes and issues
    do_wr(0, 5'd0, 32'hFFFFFFFF);
    do_iss(5'd0);
    do_rd(0, 5'd0);
    do_rd(1, 5'd0);
    #2;
    check("t3_zero_bypass", 64'(rd_data), 64'd0);
    check("t3_zero_ready", 64'(rd_ready), 64'h3);
    tick();
    idle();
    tick();
    #2;
    check("t3_cnt", 64'(busy_cnt), 64'd0);

    // 4: issue $7, wait, then write resolves it
    do_iss(5'd7);
    do_rd(1, 5'd7);
    tick();
    idle();
    tick();
    tick();
    #2;
    check("t4_not_ready", 64'(rd_ready[1]), 64'd0);
    check("t4_cnt1", 64'(busy_cnt), 64'd1);
    do_wr(0, 5'd7, 32'h55);
    #2;
    check("t4_bypass_ready", 64'(rd_ready[1]), 64'd1);
    check("t4_bypass_data", 64'(rd_data[63:32]), 64'h55);
    tick();
    idle();
    #2;
    check("t4_cnt_lag", 64'(busy_cnt), 64'd1);
    check("t4_ready_after", 64'(rd_ready[1]), 64'd1);
    tick();
    #2;
    check("t4_cnt0", 64'(busy_cnt), 64'd0);

    // 5: same-cycle issue and write of $9; re-issue does not double-count
    do_iss(5'd9);
    do_wr(0, 5'd9, 32'hAA);
    tick();
    idle();
    do_rd(0, 5'd9);
    #2;
    check("t5_stored", 64'(rd_data[31:0]), 64'hAA);
    check("t5_still_busy", 64'(rd_ready[0]), 64'd0);
    tick();
    #2;
    check("t5_cnt1", 64'(busy_cnt), 64'd1);
    do_iss(5'd9);
    tick();
    idle();
    tick();
    #2;
    check("t5_reissue_cnt", 64'(busy_cnt), 64'd1);

    // 6: two writers on $4, port 1 wins; then flush beats a same-cycle issue
    do_wr(0, 5'd4, 32'h11);
    do_wr(1, 5'd4, 32'h22);
    do_rd(1, 5'd4);
    #2;
    check("t6_bypass_prio", 64'(rd_data[63:32]), 64'h22);
    tick();
    idle();
    #2;
    check("t6_stored_prio", 64'(rd_data[63:32]), 64'h22);
    do_iss(5'd1); tick();
    do_iss(5'd2); tick();
    do_iss(5'd3); tick();
    idle();
    tick();
    #2;
    check("t6_cnt4", 64'(busy_cnt), 64'd4);
    flush = 1'b1;
    do_iss(5'd5);
    tick();
    idle();
    tick();
    #2;
    check("t6_flush_cnt", 64'(busy_cnt), 64'd0);

    // Extra pattern: distinct writes on both ports, checked every cycle by the model
    for (int i = 0; i < 8; i++) begin
      do_wr(0, 5'(10 + i), 32'hA000_0000 + 32'(i));
      do_wr(1, 5'(20 + i), 32'hB000_0000 + 32'(i));
      do_rd(0, 5'(10 + i));
      do_rd(1, 5'(19 + i));
      if (i % 3 == 0) do_iss(5'(20 + i + 1));
      else iss_en = 1'b0;
      tick();
    end
    idle();
    do_rd(0, 5'd13);
    do_rd(1, 5'd27);
    #2;
    check("x_port0", 64'(rd_data[31:0]), 64'hA000_0003);
    check("x_port1", 64'(rd_data[63:32]), 64'hB000_0007);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
